// File: rtl/wr_sched_pkg.sv
// rtl/wr_sched_pkg.sv - shared types and record-size helper for the capture-ring scheduler
package wr_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CALC,
    ST_ISSUE,
    ST_WAIT,
    ST_COMMIT
  } state_t;

  localparam int TS_BYTES_DEF = 16;

  // Ring bytes consumed by one record: payload rounded up to a word plus the header.
  function automatic logic [31:0] rec_bytes(input logic [31:0] len, input logic [31:0] ts);
    return ((len + 32'd3) & ~32'd3) + ts;
  endfunction

endpackage

// File: rtl/desc_fifo.sv
// rtl/desc_fifo.sv - synchronous first-word fall-through descriptor queue
module desc_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             ready
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [AW:0]      count;
  logic [AW:0]      count_next;
  logic             push_ok;
  logic             pop_ok;

  // ready is a register so it reads 0 in reset and never reopens while full
  assign push_ok = push && ready;
  assign pop_ok  = pop && !empty;
  assign empty   = (count == '0);
  assign dout    = mem[rptr];

  always_comb begin
    count_next = count;
    if (push_ok && !pop_ok) begin
      count_next = count + (AW+1)'(1);
    end else if (!push_ok && pop_ok) begin
      count_next = count - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      ready <= 1'b0;
    end else begin
      if (push_ok) wptr <= wptr + AW'(1);
      if (pop_ok)  rptr <= rptr + AW'(1);
      count <= count_next;
      ready <= (count_next != (AW+1)'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= din;
  end

endmodule

// File: rtl/wr_sched.sv
// rtl/wr_sched.sv - places capture records in a host ring and sequences wr_ctrl transfers
module wr_sched
  import wr_sched_pkg::*;
#(
  parameter int DESC_DEPTH = 4,
  parameter int TS_BYTES   = TS_BYTES_DEF,
  parameter int MAX_LEN    = 2048,
  parameter int TIMEOUT    = 65535
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        ring_clear,
  input  logic [31:0] ring_base,
  input  logic [31:0] ring_size,
  input  logic [31:0] ring_rd_ptr,
  input  logic [31:0] control_in,
  input  logic        desc_valid,
  output logic        desc_ready,
  input  logic [31:0] desc_begin,
  input  logic [31:0] desc_end,
  output logic        wr_ctrl,
  output logic [31:0] control,
  output logic [31:0] pkt_begin,
  output logic [31:0] pkt_end,
  output logic [31:0] write_address,
  input  logic        wr_ctrl_rdy,
  output logic [31:0] ring_wr_ptr,
  output logic [31:0] pkt_count,
  output logic [31:0] drop_count,
  output logic        busy,
  output logic        irq,
  output logic        timeout_err
);

  state_t      state, state_next;
  logic [63:0] head;
  logic        fifo_empty;
  logic        fifo_pop;
  logic [31:0] db_q, de_q, place_q, rec_q, wait_cnt;
  logic [31:0] len_c, rec_c, place_c, commit_ptr;
  logic [32:0] fit_sum, commit_sum;
  logic        drop_c;
  logic        do_latch, do_clear, do_drop, do_issue, do_commit, do_timeout;

  desc_fifo #(.DEPTH(DESC_DEPTH), .WIDTH(64)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (desc_valid),
    .din   ({desc_begin, desc_end}),
    .pop   (fifo_pop),
    .dout  (head),
    .empty (fifo_empty),
    .ready (desc_ready)
  );

  assign len_c      = de_q - db_q;
  assign rec_c      = rec_bytes(len_c, 32'(TS_BYTES));
  assign fit_sum    = {1'b0, ring_wr_ptr} + {1'b0, rec_c};
  assign commit_sum = {1'b0, place_q} + {1'b0, rec_q};
  assign commit_ptr = (commit_sum == {1'b0, ring_size}) ? 32'd0 : commit_sum[31:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    fifo_pop   = 1'b0;
    do_latch   = 1'b0;
    do_clear   = 1'b0;
    do_drop    = 1'b0;
    do_issue   = 1'b0;
    do_commit  = 1'b0;
    do_timeout = 1'b0;
    drop_c     = 1'b0;
    place_c    = ring_wr_ptr;

    // Strict compares keep wr == rd reserved for an empty ring.
    if (de_q <= db_q || len_c > 32'(MAX_LEN)) begin
      drop_c = 1'b1;
    end else if (ring_wr_ptr >= ring_rd_ptr) begin
      if (fit_sum < {1'b0, ring_size} ||
          (fit_sum == {1'b0, ring_size} && ring_rd_ptr != 32'd0)) begin
        place_c = ring_wr_ptr;
      end else if (rec_c < ring_rd_ptr) begin
        place_c = 32'd0;
      end else begin
        drop_c = 1'b1;
      end
    end else if (fit_sum >= {1'b0, ring_rd_ptr}) begin
      drop_c = 1'b1;
    end

    case (state)
      ST_IDLE: begin
        if (ring_clear) begin
          do_clear = 1'b1;
        end else if (enable && !fifo_empty) begin
          do_latch   = 1'b1;
          state_next = ST_CALC;
        end
      end
      ST_CALC: begin
        if (drop_c) begin
          do_drop    = 1'b1;
          fifo_pop   = 1'b1;
          state_next = ST_IDLE;
        end else begin
          do_issue   = 1'b1;
          state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: state_next = ST_WAIT;
      ST_WAIT: begin
        if (wr_ctrl_rdy) begin
          state_next = ST_COMMIT;
        end else if (wait_cnt == 32'(TIMEOUT - 1)) begin
          do_timeout = 1'b1;
          fifo_pop   = 1'b1;
          state_next = ST_IDLE;
        end
      end
      ST_COMMIT: begin
        do_commit  = 1'b1;
        fifo_pop   = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      db_q          <= '0;
      de_q          <= '0;
      place_q       <= '0;
      rec_q         <= '0;
      wait_cnt      <= '0;
      wr_ctrl       <= 1'b0;
      control       <= '0;
      pkt_begin     <= '0;
      pkt_end       <= '0;
      write_address <= '0;
      ring_wr_ptr   <= '0;
      pkt_count     <= '0;
      drop_count    <= '0;
      busy          <= 1'b0;
      irq           <= 1'b0;
      timeout_err   <= 1'b0;
    end else begin
      wr_ctrl <= do_issue;
      irq     <= do_commit;
      busy    <= (state_next != ST_IDLE);
      if (do_clear) ring_wr_ptr <= '0;
      if (do_latch) begin
        db_q <= head[63:32];
        de_q <= head[31:0];
      end
      if (do_drop) drop_count <= drop_count + 32'd1;
      // Transfer arguments are captured once and held through WAIT.
      if (do_issue) begin
        place_q       <= place_c;
        rec_q         <= rec_c;
        write_address <= ring_base + place_c;
        pkt_begin     <= db_q;
        pkt_end       <= de_q;
        control       <= control_in;
        wait_cnt      <= '0;
      end
      if (state == ST_WAIT) wait_cnt <= wait_cnt + 32'd1;
      if (do_timeout) timeout_err <= 1'b1;
      if (do_commit) begin
        ring_wr_ptr <= commit_ptr;
        pkt_count   <= pkt_count + 32'd1;
      end
    end
  end

endmodule
